uart_bps_gen: RTL and testbench
===============================

# uart_bps_gen

Parametrised UART bit-timing generator: counts system clocks per bit period at a run-time selectable baud rate and emits a mid-bit sample strobe, a bit-end strobe, the current bit index and a frame-done pulse. It serves both the TX shifter (bit-end strobe) and the RX sampler (mid-bit strobe), replacing fixed-rate, single-strobe bit-period counters in the serial path.

## Interface
- CNT_W, 16: width of the bit-period counter.
- DIV0, 10417: clocks per bit for Baud_Sel=0 (9600 @ 100 MHz).
- DIV1, 5208: clocks per bit for Baud_Sel=1 (19200).
- DIV2, 868: clocks per bit for Baud_Sel=2 (115200).
- DIV3, 434: clocks per bit for Baud_Sel=3 (230400).

- CLK  in  1  system clock; single clock domain, all logic on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- Count_Sig  in  1  run request, level-sensitive; high starts/continues a frame, low aborts.
- Baud_Sel  in  2  selects DIV0..DIV3; sampled only at frame start.
- Frame_Len  in  4  bit periods per frame, 1..15; 0 means 16; sampled only at frame start.
- BPS_CLK  out  1  one-cycle mid-bit strobe.
- Bit_End  out  1  one-cycle strobe on the last clock of each bit period.
- Bit_Idx  out  4  index of the current bit period, 0-based.
- Frame_Done  out  1  one-cycle pulse coincident with the final Bit_End of a frame.
- Busy  out  1  high while in RUN.

## Operation
- States: IDLE, RUN. Registers: state, Count_BPS[CNT_W-1:0], Bit_Idx, Div_Reg, Len_Reg.
- IDLE: Count_BPS=0, Bit_Idx=0. If Count_Sig=1 at an edge: Div_Reg<=DIV[Baud_Sel]-1, Len_Reg<=Frame_Len (0→16), Count_BPS<=0, go to RUN.
- RUN, Count_Sig=1: Count_BPS increments each edge. When Count_BPS==Div_Reg it wraps to 0 and Bit_Idx increments. If Bit_Idx==Len_Reg-1 at that point, the next state is IDLE.
- RUN, Count_Sig=0: next state IDLE, counters cleared. No Bit_End or Frame_Done is issued for the partial bit.
- Decoded outputs are combinational from registered state and are gated by RUN:
  - BPS_CLK = (Count_BPS == Div_Reg>>1), i.e. floor((DIV-1)/2).
  - Bit_End = (Count_BPS == Div_Reg).
  - Frame_Done = Bit_End && (Bit_Idx == Len_Reg-1).
- Changes to Baud_Sel and Frame_Len during RUN are ignored until the next start.
- If Count_Sig is still high after Frame_Done, the block spends exactly one cycle in IDLE, then restarts with freshly sampled Baud_Sel and Frame_Len.
- Arithmetic: the counter is unsigned. Each DIVn must satisfy 2 ≤ DIVn ≤ 2^CNT_W; violation is an elaboration-time error.

## Timing
- Reset: state=IDLE; Count_BPS, Bit_Idx, Div_Reg and Len_Reg are 0. All outputs are 0 in the cycle after RST is sampled high.
- RST has priority over Count_Sig. Reset mid-frame gives IDLE on the next edge, with no strobes in that cycle or after.
- Start edge E0 (Count_Sig sampled high in IDLE): Busy=1 from E0.
  - BPS_CLK is high in the cycle after edge E0+floor((DIV-1)/2).
  - Bit_End is high in the cycle after edge E0+DIV-1.
  - Bit period is exactly DIV clocks.
- Frame length: Len×DIV clocks of Busy, followed by at least 1 cycle of Busy=0.
- Bit_Idx updates on the edge that ends Bit_End. It holds its last value of Len-1 during the final Bit_End, then reads 0 in IDLE.
- Strobes never overlap: the DIVn ≥ 2 constraint keeps BPS_CLK and Bit_End on different counts.

## Structure
- Package uart_bps_pkg holds:
  - state enum {IDLE, RUN};
  - default divisor constants;
  - Frame_Len zero-means-16 decode function.
- No sub-module. The divisor mux, counter and FSM stay flat in one module.

## Test plan
- Reset with Count_Sig=1 held: all outputs 0 while RST=1. First BPS_CLK follows 434 cycles after RST release plus the start edge (Baud_Sel=2).
- Baud_Sel=2, Frame_Len=10, Count_Sig high for one frame:
  - 10 Bit_End pulses, 868 cycles apart.
  - BPS_CLK exactly 433 cycles after each bit start.
  - Single Frame_Done on the 10th Bit_End; Busy high for 8680 cycles.
- Baud_Sel switched 2→0 mid-frame: the current frame keeps the 868-cycle period. The next frame, after a 1-cycle gap, uses a 10417-cycle period.
- Count_Sig dropped at bit 3, count 500: no Bit_End/Frame_Done, Busy=0 next cycle, Bit_Idx=0.
- Frame_Len=0 with DIV3: 16 Bit_End pulses, Frame_Done with Bit_Idx=15.
- Elaboration with DIV1=1 fails the parameter check.

Source files
------------

// File: rtl/uart_bps_pkg.sv
// Shared state type, default divisors and decode helpers for the UART bit-timing generator.
package uart_bps_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bps_state_e;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_DIV0  = 10417;
    localparam int DEF_DIV1  = 5208;
    localparam int DEF_DIV2  = 868;
    localparam int DEF_DIV3  = 434;

    // A frame length field of zero encodes the maximum of sixteen bit periods.
    function automatic logic [4:0] frame_len_decode(input logic [3:0] len);
        logic [4:0] dec;
        if (len == 4'd0) begin
            dec = 5'd16;
        end else begin
            dec = {1'b0, len};
        end
        return dec;
    endfunction

    function automatic bit div_ok(input int div, input int cnt_w);
        return (div >= 32'sd2) && (longint'(div) <= (64'sd1 <<< cnt_w));
    endfunction

endpackage

// File: rtl/uart_bps_gen.sv
// UART bit-timing generator: per-frame divisor select, bit-period counter and
// decoded mid-bit / bit-end / frame-done strobes for the TX and RX paths.
module uart_bps_gen
    import uart_bps_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DIV0  = DEF_DIV0,
    parameter int DIV1  = DEF_DIV1,
    parameter int DIV2  = DEF_DIV2,
    parameter int DIV3  = DEF_DIV3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Count_Sig,
    input  logic [1:0] Baud_Sel,
    input  logic [3:0] Frame_Len,
    output logic       BPS_CLK,
    output logic       Bit_End,
    output logic [3:0] Bit_Idx,
    output logic       Frame_Done,
    output logic       Busy
);

    if (!div_ok(DIV0, CNT_W) || !div_ok(DIV1, CNT_W) ||
        !div_ok(DIV2, CNT_W) || !div_ok(DIV3, CNT_W)) begin : g_div_check
        $fatal(1, "uart_bps_gen: every DIVn must lie in 2..2**CNT_W");
    end

    // Terminal counts are stored as DIV-1 so a full 2**CNT_W period still fits the counter.
    localparam logic [CNT_W-1:0] DIV0_M1 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] DIV1_M1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] DIV2_M1 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] DIV3_M1 = CNT_W'(DIV3 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    bps_state_e       r_state;
    bps_state_e       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_div;
    logic [3:0]       r_bit_idx;
    logic [4:0]       r_len;
    logic [CNT_W-1:0] w_div_sel;
    logic             w_run;
    logic             w_bit_end;
    logic             w_last_bit;

    assign w_run      = (r_state == RUN);
    assign w_bit_end  = w_run && (r_count == r_div);
    assign w_last_bit = ({1'b0, r_bit_idx} == (r_len - 5'd1));

    // Divisor selection, only captured into r_div at frame start.
    always_comb begin
        case (Baud_Sel)
            2'd0:    w_div_sel = DIV0_M1;
            2'd1:    w_div_sel = DIV1_M1;
            2'd2:    w_div_sel = DIV2_M1;
            2'd3:    w_div_sel = DIV3_M1;
            default: w_div_sel = DIV0_M1;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a dropped run request aborts the frame immediately.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (Count_Sig) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (!Count_Sig) begin
                    w_next_state = IDLE;
                end else if (w_bit_end && w_last_bit) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Bit-period counter, bit index and per-frame divisor/length capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count   <= '0;
            r_bit_idx <= 4'd0;
            r_div     <= '0;
            r_len     <= 5'd0;
        end else if (r_state == IDLE) begin
            r_count   <= '0;
            r_bit_idx <= 4'd0;
            if (Count_Sig) begin
                r_div <= w_div_sel;
                r_len <= frame_len_decode(Frame_Len);
            end else begin
                r_div <= r_div;
                r_len <= r_len;
            end
        end else if (w_next_state == IDLE) begin
            r_count   <= '0;
            r_bit_idx <= 4'd0;
        end else if (w_bit_end) begin
            r_count   <= '0;
            r_bit_idx <= r_bit_idx + 4'd1;
        end else begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign BPS_CLK    = w_run && (r_count == (r_div >> 1));
    assign Bit_End    = w_bit_end;
    assign Frame_Done = w_bit_end && w_last_bit;
    assign Bit_Idx    = w_run ? r_bit_idx : 4'd0;
    assign Busy       = w_run;

endmodule

// File: tb/tb_uart_bps_gen.sv
// Scoreboard bench for uart_bps_gen: frame-level reference model pushes expected
// strobe and Busy events; a negedge monitor pops and compares them.
module tb_uart_bps_gen;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Count_Sig;
    logic [1:0] Baud_Sel;
    logic [3:0] Frame_Len;
    logic       BPS_CLK;
    logic       Bit_End;
    logic [3:0] Bit_Idx;
    logic       Frame_Done;
    logic       Busy;

    uart_bps_gen dut (
        .CLK(CLK), .RST(RST), .Count_Sig(Count_Sig), .Baud_Sel(Baud_Sel),
        .Frame_Len(Frame_Len), .BPS_CLK(BPS_CLK), .Bit_End(Bit_End),
        .Bit_Idx(Bit_Idx), .Frame_Done(Frame_Done), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // vec = {BPS_CLK, Bit_End, Frame_Done, Bit_Idx}; for Busy events vec[0] is the new level
    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } ev_t;

    ev_t  q_s[$];
    ev_t  q_b[$];
    ev_t  e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    logic prev_busy = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int div_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 10417;
            2'd1:    return 5208;
            2'd2:    return 868;
            default: return 434;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected events for one frame that starts at edge e0 and leaves RUN at edge stop.
    task automatic push_frame(input int e0, input int d, input int l, input int stop);
        int t;
        q_b.push_back('{e0, 7'd1});
        for (int b = 0; b < l; b++) begin
            t = e0 + b * d + (d - 1) / 2;
            if (t < stop) q_s.push_back('{t, {3'b100, 4'(b)}});
            t = e0 + b * d + d - 1;
            if (t < stop) q_s.push_back('{t, {2'b01, (b == l - 1), 4'(b)}});
        end
        q_b.push_back('{stop, 7'd0});
    endtask

    // kind: 0 full frame, 1 Count_Sig dropped, 2 RST pulsed; abort edge is e0+abort_at.
    task automatic frame(input logic [1:0] sel, input logic [3:0] flen, input int abort_at,
                         input int kind, input bit keep_high, input bit scramble,
                         input bit mid_chg, input logic [1:0] mid_sel, input logic [3:0] mid_len);
        int e0, d, l, stop;
        Baud_Sel  = sel;
        Frame_Len = flen;
        Count_Sig = 1'b1;
        e0   = cyc + 1;
        d    = div_of(sel);
        l    = (flen == 4'd0) ? 16 : int'(flen);
        stop = (kind == 0) ? e0 + l * d : e0 + abort_at;
        push_frame(e0, d, l, stop);
        while (cyc < stop - 1) begin
            @(negedge CLK);
            if (mid_chg && cyc == e0 + (stop - e0) / 2) begin
                Baud_Sel  = mid_sel;
                Frame_Len = mid_len;
            end else if (scramble && $urandom_range(0, 49) == 0) begin
                Baud_Sel  = 2'($urandom);
                Frame_Len = 4'($urandom);
            end
        end
        if (kind == 1) Count_Sig = 1'b0;
        else if (kind == 2) RST = 1'b1;
        @(negedge CLK);
        chk("idle_busy", int'(Busy), 0);
        chk("idle_bit_idx", int'(Bit_Idx), 0);
        if (kind == 2) begin
            chk("rst_outputs", int'({BPS_CLK, Bit_End, Frame_Done, Busy, Bit_Idx}), 0);
            RST = 1'b0;
        end
        if (!keep_high) Count_Sig = 1'b0;
    endtask

    // Monitor: every strobe or Busy change must match the head of its queue at this cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            while (q_s.size() > 0 && q_s[0].cyc < cyc) begin
                n_checks++; n_err++;
                $display("FAIL strobe_missing: expected vec %0h at cycle %0d, not observed", q_s[0].vec, q_s[0].cyc);
                void'(q_s.pop_front());
            end
            while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
                n_checks++; n_err++;
                $display("FAIL busy_missing: expected Busy=%0d at cycle %0d, no change seen", q_b[0].vec[0], q_b[0].cyc);
                void'(q_b.pop_front());
            end
            if (BPS_CLK || Bit_End || Frame_Done) begin
                n_checks++;
                if (q_s.size() == 0 || q_s[0].cyc != cyc) begin
                    n_err++;
                    $display("FAIL strobe_unexpected: cycle %0d got vec %0h, required no strobe",
                             cyc, {BPS_CLK, Bit_End, Frame_Done, Bit_Idx});
                end else begin
                    e = q_s.pop_front();
                    if ({BPS_CLK, Bit_End, Frame_Done, Bit_Idx} !== e.vec) begin
                        n_err++;
                        $display("FAIL strobe_value: cycle %0d got vec %0h, required %0h",
                                 cyc, {BPS_CLK, Bit_End, Frame_Done, Bit_Idx}, e.vec);
                    end
                end
            end
            if (Busy !== prev_busy) begin
                n_checks++;
                if (q_b.size() == 0 || q_b[0].cyc != cyc || q_b[0].vec[0] !== Busy) begin
                    n_err++;
                    $display("FAIL busy_edge: cycle %0d got Busy=%0b, required no change here", cyc, Busy);
                end else begin
                    void'(q_b.pop_front());
                end
            end
            prev_busy = Busy;
        end
    end

    initial begin
        logic [1:0] sel;
        logic [3:0] len;
        int         l, kind, ab;
        bit         keep;
        RST       = 1'b1;
        Count_Sig = 1'b1;
        Baud_Sel  = 2'd2;
        Frame_Len = 4'd1;
        @(negedge CLK);
        mon_en = 1'b1;
        repeat (4) begin
            chk("reset_outputs", int'({BPS_CLK, Bit_End, Frame_Done, Busy, Bit_Idx}), 0);
            @(negedge CLK);
        end
        RST = 1'b0;
        // Start immediately after reset release, DIV2 single bit
        frame(2'd2, 4'd1, 0, 0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        // Ten-bit DIV2 frame with Baud_Sel/Frame_Len changed mid-frame
        frame(2'd2, 4'd10, 0, 0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd1);
        // Following frame picks up DIV0 after the one-cycle gap
        frame(2'd0, 4'd1, 0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        repeat (3) @(negedge CLK);
        // Abort while bit 3 has count 500
        frame(2'd2, 4'd10, 3 * 868 + 501, 1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        repeat (2) @(negedge CLK);
        // Frame_Len=0 means sixteen bits
        frame(2'd3, 4'd0, 0, 0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        // Reset mid-frame
        frame(2'd3, 4'd5, 1000, 2, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        for (int k = 0; k < 6; k++) begin
            sel  = 2'($urandom_range(2, 3));
            len  = (sel == 2'd2) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
            l    = (len == 4'd0) ? 16 : int'(len);
            kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            ab   = int'($urandom_range(1, l * div_of(sel) - 1));
            keep = 1'($urandom_range(0, 1));
            frame(sel, len, ab, kind, keep, 1'b1, 1'b0, 2'd0, 4'd0);
            if (!keep) repeat ($urandom_range(1, 5)) @(negedge CLK);
        end
        frame(2'd1, 4'd1, 0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        repeat (3) @(negedge CLK);
        chk("queues_drained", q_s.size() + q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
